// File: rtl/spi_ram_ctrl.sv
// Command-decoding byte RAM behind the SPI slave: decodes rx_data[9:8] into
// write-address / write-data / read-address / read-data. Optional macro SPI_RAM_AUTO_INC_EN.
module spi_ram_ctrl #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_SIZE+1:0] rx_data,
  input  logic                 rx_valid,
  output logic [ADDR_SIZE-1:0] tx_data,
  output logic                 tx_valid,
  output logic                 err_seq
);

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

`ifdef SPI_RAM_AUTO_INC_EN
  localparam bit AUTO_INC = 1'b1;
`else
  localparam bit AUTO_INC = 1'b0;
`endif

  localparam logic [ADDR_SIZE-1:0] ADDR_ONE = ADDR_SIZE'(1);

  logic [ADDR_SIZE-1:0] mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic                 wa_vld;
  logic                 ra_vld;
  logic                 rx_valid_q;

  cmd_e                 cmd;
  logic [ADDR_SIZE-1:0] payload;
  logic                 accept;
  logic                 wr_en;

  assign cmd     = cmd_e'(rx_data[ADDR_SIZE+1:ADDR_SIZE]);
  assign payload = rx_data[ADDR_SIZE-1:0];
  // A held-high rx_valid must not re-trigger, so only its rising edge accepts.
  assign accept  = rx_valid && !rx_valid_q;
  assign wr_en   = accept && (cmd == CMD_WR_DATA) && wa_vld;

  // NOTE: the memory array has no reset; clearing it would force a flop array
  // instead of RAM, and its contents are meant to survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= payload;
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, e.g. tx_data reads mem before a same-edge write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid_q <= 1'b0;
      wr_addr    <= '0;
      rd_addr    <= '0;
      wa_vld     <= 1'b0;
      ra_vld     <= 1'b0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      err_seq    <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid;
      err_seq    <= 1'b0;
      if (accept) begin
        // Any accept other than RD_DATA ends the read-data hold window.
        tx_valid <= 1'b0;
        unique case (cmd)
          CMD_WR_ADDR: begin
            wr_addr <= payload;
            wa_vld  <= 1'b1;
          end
          CMD_WR_DATA: begin
            if (!wa_vld)       err_seq <= 1'b1;
            else if (AUTO_INC) wr_addr <= wr_addr + ADDR_ONE;
          end
          CMD_RD_ADDR: begin
            rd_addr <= payload;
            ra_vld  <= 1'b1;
          end
          CMD_RD_DATA: begin
            tx_data  <= mem[rd_addr];
            tx_valid <= 1'b1;
            if (!ra_vld)  err_seq <= 1'b1;
            if (AUTO_INC) rd_addr <= rd_addr + ADDR_ONE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed self-checking bench for spi_ram_ctrl; expectations follow
// SPI_RAM_AUTO_INC_EN when it is defined for the compile.
module tb_spi_ram_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       err_seq;

  int n_checks = 0;
  int n_fail   = 0;

  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .err_seq  (err_seq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Raise rx_valid on a falling edge, hold it for n rising edges, then drop it.
  // Returns on the falling edge after the accept, where results are visible.
  task automatic send_hold(input logic [9:0] word, input int n);
    @(negedge clk);
    rx_data  = word;
    rx_valid = 1'b1;
    repeat (n) @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send(input logic [9:0] word);
    send_hold(word, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_tx_data", tx_data, 8'h00);
    check("reset_tx_valid", {7'b0, tx_valid}, 8'h00);
    check("reset_err_seq", {7'b0, err_seq}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic write then read at 0x12
    send(10'h0_12);
    send(10'h1_A5);
    send(10'h2_12);
    send(10'h3_00);
    check("wr_rd_data", tx_data, 8'hA5);
    check("wr_rd_valid", {7'b0, tx_valid}, 8'h01);
    check("wr_rd_no_err", {7'b0, err_seq}, 8'h00);
    repeat (3) @(negedge clk);
    check("hold_data", tx_data, 8'hA5);
    check("hold_valid", {7'b0, tx_valid}, 8'h01);

    // Next accept drops tx_valid; also seed mem[00]=5A for later reads
    send(10'h0_00);
    check("wr_addr_drops_valid", {7'b0, tx_valid}, 8'h00);
    send(10'h1_5A);

    // Level held 10 cycles must write exactly once
    send(10'h0_40);
    send_hold(10'h1_3C, 10);
    send(10'h1_99);
    send(10'h2_40);
    send(10'h3_00);
`ifdef SPI_RAM_AUTO_INC_EN
    check("level_mem40", tx_data, 8'h3C);
    send(10'h3_00);
    check("level_mem41", tx_data, 8'h99);
`else
    check("level_mem40", tx_data, 8'h99);
`endif

    // Consecutive reads keep tx_valid high
    send(10'h0_05);
    send(10'h1_11);
    send(10'h0_06);
    send(10'h1_22);
    send(10'h2_05);
    send(10'h3_00);
    check("rd1_data", tx_data, 8'h11);
    check("rd1_valid", {7'b0, tx_valid}, 8'h01);
    @(negedge clk);
    check("rd_gap_valid", {7'b0, tx_valid}, 8'h01);
    send(10'h3_00);
`ifdef SPI_RAM_AUTO_INC_EN
    check("rd2_data", tx_data, 8'h22);
`else
    check("rd2_data", tx_data, 8'h11);
`endif
    check("rd2_valid", {7'b0, tx_valid}, 8'h01);
    send(10'h0_07);
    check("rd_then_wa_valid", {7'b0, tx_valid}, 8'h00);

    // Asynchronous reset while tx_valid is high
    send(10'h3_00);
    check("pre_reset_valid", {7'b0, tx_valid}, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_tx_data", tx_data, 8'h00);
    check("async_rst_tx_valid", {7'b0, tx_valid}, 8'h00);
    check("async_rst_err_seq", {7'b0, err_seq}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // RD_DATA without RD_ADDR: error pulse, reads rd_addr 0, memory survived reset
    send(10'h3_00);
    check("rd_no_ra_err", {7'b0, err_seq}, 8'h01);
    check("rd_no_ra_data", tx_data, 8'h5A);
    @(negedge clk);
    check("rd_no_ra_err_clear", {7'b0, err_seq}, 8'h00);

    // WR_DATA without WR_ADDR, held high: exactly one error pulse, no write
    @(negedge clk);
    rx_data  = 10'h1_77;
    rx_valid = 1'b1;
    @(negedge clk);
    check("seq_err_pulse", {7'b0, err_seq}, 8'h01);
    check("seq_err_drops_valid", {7'b0, tx_valid}, 8'h00);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("seq_err_once_%0d", i), {7'b0, err_seq}, 8'h00);
    end
    rx_valid = 1'b0;
    send(10'h2_00);
    check("ra_no_err", {7'b0, err_seq}, 8'h00);
    send(10'h3_00);
    check("seq_err_no_write", tx_data, 8'h5A);
    check("seq_err_rd_no_err", {7'b0, err_seq}, 8'h00);

`ifdef SPI_RAM_AUTO_INC_EN
    // Address wrap from FF to 00
    send(10'h0_FF);
    send(10'h1_01);
    send(10'h1_02);
    send(10'h2_FF);
    send(10'h3_00);
    check("wrap_memFF", tx_data, 8'h01);
    send(10'h3_00);
    check("wrap_mem00", tx_data, 8'h02);
    check("wrap_valid", {7'b0, tx_valid}, 8'h01);
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
